rx_frame_buf: RTL and testbench
===============================

RX_FRAME_BUF -- requirements
Module: rx_frame_buf

Interface
REQ-001 Parameter ADDR_W, default 11, buffer address width; depth = 2^ADDR_W words.
REQ-002 Parameter FRAME_MAX, default 1518, maximum accepted frame length in bytes.
REQ-003 tx_clk  input  1  single clock for all logic; rx and tx share it in loopback.
REQ-004 rst_n  input  1  reset; the reset is asynchronous and active-low.
REQ-005 clk_ten  input  1  clock enable; all state advances only on edges where clk_ten=1.
REQ-006 tsmac_rstart  input  1  first byte of a received frame.
REQ-007 tsmac_rdata  input  8  received byte.
REQ-008 tsmac_rvalid  input  1  tsmac_rdata valid.
REQ-009 tsmac_rlast  input  1  last byte of the frame, qualified by tsmac_rvalid.
REQ-010 tsmac_rgood  input  1  frame status, sampled only with tsmac_rlast&tsmac_rvalid; 1 = good frame.
REQ-011 rd_en  input  1  read request from the downstream transmit sequencer.
REQ-012 rd_data  output  18  [7:0] byte, [8] last-of-frame, [17:9] zero.
REQ-013 data_out_valid  output  1  at least one complete committed frame is unread.
REQ-014 frame_rdy  output  1  one-cycle pulse per committed frame; wakes the transmit sequencer from idle.
REQ-015 frame_cnt  output  16  committed frames, saturating at 16'hFFFF.
REQ-016 drop_cnt  output  16  discarded frames, saturating at 16'hFFFF.

Function
REQ-017 Write FSM states: W_IDLE, W_RECV, W_DROP.
REQ-018 W_IDLE -> W_RECV on tsmac_rstart&tsmac_rvalid; that first byte is written.
REQ-019 In W_RECV, each valid byte is written at wr_ptr as {9'b0, tsmac_rlast, tsmac_rdata}, then wr_ptr increments modulo depth.
REQ-020 A good last byte (rlast&rgood) sets commit_ptr to wr_ptr+1, pulses frame_rdy the next enabled cycle, increments pend_frames and frame_cnt, and returns to W_IDLE.
REQ-021 A bad last byte (rlast&!rgood) restores wr_ptr to commit_ptr, increments drop_cnt, and returns to W_IDLE.
REQ-022 Overflow drop: a valid byte arriving with free space 0 (wr_ptr+1 == rd_ptr) is not written; wr_ptr restores to commit_ptr; the FSM enters W_DROP.
REQ-023 Length drop: the byte counter reaching FRAME_MAX with another non-last valid byte triggers the same rollback and entry to W_DROP.
REQ-024 W_DROP discards all bytes until rlast&rvalid, then increments drop_cnt once and returns to W_IDLE.
REQ-025 tsmac_rstart in W_RECV or W_DROP (missing rlast) rolls back the partial frame, increments drop_cnt, and starts the new frame in W_RECV.
REQ-026 A single-byte frame (rstart and rlast on the same byte) is legal and commits or drops per rgood.
REQ-027 Read side: rd_en with committed data (rd_ptr != commit_ptr) registers buffer[rd_ptr] into rd_data one enabled cycle later and increments rd_ptr.
REQ-028 rd_en with no committed data is ignored; rd_ptr and rd_data hold.
REQ-029 Reading a word with bit[8]=1 decrements pend_frames; data_out_valid = (pend_frames != 0).
REQ-030 Simultaneous commit and last-word read leave pend_frames unchanged.
REQ-031 The reader never passes commit_ptr; the writer never overwrites unread words; pointers wrap modulo depth.

Reset
REQ-032 On rst_n=0, asynchronously: FSM to W_IDLE; wr_ptr, commit_ptr, rd_ptr, pend_frames, and byte counter to 0; rd_data 18'h0; data_out_valid, frame_rdy 0; frame_cnt, drop_cnt 0.
REQ-033 Reset mid-frame discards all buffer contents without counting a drop; buffer RAM contents are not reset.

Structure
REQ-034 FSM state encodings and the word field positions (LAST_BIT=8, DATA_MSB=7) live in a shared package used with the transmit sequencer.
REQ-035 The storage is one sub-module, frame_ram: simple dual-port, 18-bit, 2^ADDR_W deep, registered read, write and read gated by clk_ten.

Verification
REQ-036 Good 64-byte frame, then rd_en held -> frame_rdy pulses once; 64 words read; word 63 has bit8=1; data_out_valid falls after it; frame_cnt=1.
REQ-037 Bad 100-byte frame (rgood=0), then a good 60-byte frame -> drop_cnt=1, frame_cnt=1; reader sees only the 60 bytes.
REQ-038 ADDR_W=6 with a 70-byte frame -> overflow drop; drop_cnt=1; a following 20-byte frame commits correctly.
REQ-039 FRAME_MAX=64 with a 65-byte frame -> dropped; a 64-byte frame is accepted.
REQ-040 Commit of frame 2 in the same cycle as the last-word read of frame 1 -> pend_frames stays 1 and data_out_valid stays 1.
REQ-041 clk_ten toggling 1-in-10 with rst_n asserted mid-frame -> all outputs 0; the next frame passes intact.

Source files
------------

// File: rtl/rx_frame_buf_pkg.sv
// Shared definitions for the receive frame buffer and the transmit sequencer that drains it:
// write-FSM encodings, buffer word layout and a saturating counter helper.
package rx_frame_buf_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RECV = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    localparam int WORD_W   = 18;
    localparam int LAST_BIT = 8;
    localparam int DATA_MSB = 7;
    localparam int CNT_W    = 16;

    // Adds 0..2 to a statistics counter, sticking at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/rx_frame_buf_frame_ram.sv
// Simple dual-port frame storage: one write port, one registered read port, both gated by
// the clock enable so the buffer advances in step with the rest of the receive path.
module frame_ram
    import rx_frame_buf_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int WIDTH  = WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ten,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [2**ADDR_W];
    logic [WIDTH-1:0] r_rd_data;

    // NOTE: the array has no reset branch so it maps onto block RAM; only the output register resets.
    always_ff @(posedge clk) begin
        if (i_ten && i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // NOTE: state is always updated with <= so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_ten && i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rx_frame_buf.sv
// Receive frame buffer: stores MAC bytes, commits good frames, rolls back bad, oversize or
// overflowing ones, and hands committed frames to the transmit sequencer in loopback.
module rx_frame_buf
    import rx_frame_buf_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int FRAME_MAX = 1518
) (
    input  logic              tx_clk,
    input  logic              rst_n,
    input  logic              clk_ten,
    input  logic              tsmac_rstart,
    input  logic [7:0]        tsmac_rdata,
    input  logic              tsmac_rvalid,
    input  logic              tsmac_rlast,
    input  logic              tsmac_rgood,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              data_out_valid,
    output logic              frame_rdy,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef logic [ADDR_W-1:0] ptr_t;

    wr_state_t        r_state, w_next_state;
    ptr_t             r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_byte_cnt, r_frame_cnt, r_drop_cnt;
    logic [ADDR_W:0]  r_pend;
    logic             r_rd_fire, r_frame_rdy;

    logic              w_start, w_abort, w_take, w_full, w_too_long, w_reject;
    ptr_t              w_base, w_base_inc, w_wr_ptr_nxt;
    logic [CNT_W-1:0]  w_cnt_cur, w_cnt_nxt;
    logic              w_wr_en, w_commit, w_rd_fire, w_pend_dec;
    logic [1:0]        w_drop_inc;
    logic [WORD_W-1:0] w_wr_word, w_ram_q;

    assign w_start = tsmac_rvalid & tsmac_rstart;
    assign w_abort = w_start & (r_state != W_IDLE);
    assign w_take  = tsmac_rvalid & (w_start | (r_state == W_RECV));

    // A start byte always lands on commit_ptr, which also discards an unfinished frame.
    assign w_base     = w_start ? r_commit_ptr : r_wr_ptr;
    assign w_base_inc = w_base + ptr_t'(1);
    assign w_cnt_cur  = w_start ? '0 : r_byte_cnt;
    assign w_full     = (w_base_inc == r_rd_ptr);
    assign w_too_long = (w_cnt_cur == CNT_W'(FRAME_MAX));
    assign w_reject   = w_full | w_too_long;

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= W_IDLE;
        end else if (clk_ten) begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (w_take) begin
            if (tsmac_rlast) begin
                w_next_state = W_IDLE;
            end else if (w_reject) begin
                w_next_state = W_DROP;
            end else begin
                w_next_state = W_RECV;
            end
        end else if ((r_state == W_DROP) && tsmac_rvalid && tsmac_rlast) begin
            w_next_state = W_IDLE;
        end
    end

    always_comb begin
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        w_drop_inc   = 2'd0;
        w_wr_ptr_nxt = r_wr_ptr;
        w_cnt_nxt    = r_byte_cnt;
        if (w_abort) begin
            w_drop_inc = 2'd1;
        end
        if (w_take) begin
            if (w_reject) begin
                // A rejected last byte ends the frame here rather than swallowing the next one.
                w_wr_ptr_nxt = r_commit_ptr;
                if (tsmac_rlast) begin
                    w_drop_inc = w_drop_inc + 2'd1;
                end
            end else begin
                w_wr_en      = 1'b1;
                w_wr_ptr_nxt = w_base_inc;
                w_cnt_nxt    = w_cnt_cur + CNT_W'(1);
                if (tsmac_rlast && tsmac_rgood) begin
                    w_commit = 1'b1;
                end else if (tsmac_rlast) begin
                    w_wr_ptr_nxt = r_commit_ptr;
                    w_drop_inc   = w_drop_inc + 2'd1;
                end
            end
        end else if ((r_state == W_DROP) && tsmac_rvalid && tsmac_rlast) begin
            w_drop_inc = 2'd1;
        end
    end

    always_comb begin
        w_wr_word               = '0;
        w_wr_word[LAST_BIT]     = tsmac_rlast;
        w_wr_word[DATA_MSB:0]   = tsmac_rdata;
    end

    assign w_rd_fire = rd_en & (r_rd_ptr != r_commit_ptr);
    // The word appears one edge after the read, so its last bit retires the frame on the next enabled edge.
    assign w_pend_dec = r_rd_fire & w_ram_q[LAST_BIT];

    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_byte_cnt   <= '0;
            r_pend       <= '0;
            r_rd_fire    <= 1'b0;
            r_frame_rdy  <= 1'b0;
            r_frame_cnt  <= '0;
            r_drop_cnt   <= '0;
        end else if (clk_ten) begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_byte_cnt  <= w_cnt_nxt;
            r_rd_fire   <= w_rd_fire;
            r_frame_rdy <= w_commit;
            r_frame_cnt <= sat_add(r_frame_cnt, {1'b0, w_commit});
            r_drop_cnt  <= sat_add(r_drop_cnt, w_drop_inc);
            if (w_commit) begin
                r_commit_ptr <= w_base_inc;
            end
            if (w_rd_fire) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end
            case ({w_commit, w_pend_dec})
                2'b10:   r_pend <= r_pend + (ADDR_W+1)'(1);
                2'b01:   r_pend <= r_pend - (ADDR_W+1)'(1);
                default: r_pend <= r_pend;
            endcase
        end
    end

    frame_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (WORD_W)
    ) u_frame_ram (
        .clk       (tx_clk),
        .rst_n     (rst_n),
        .i_ten     (clk_ten),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_base),
        .i_wr_data (w_wr_word),
        .i_rd_en   (w_rd_fire),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    assign rd_data        = w_ram_q;
    assign data_out_valid = (r_pend != '0);
    assign frame_rdy      = r_frame_rdy;
    assign frame_cnt      = r_frame_cnt;
    assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_rx_frame_buf.sv
// Directed bench for rx_frame_buf: three instances (default, 64-word buffer, 64-byte frame limit)
// share the stimulus bus; only the instance under test receives clock enables.
module tb_rx_frame_buf;

    logic             tx_clk = 1'b0;
    logic             rst_n  = 1'b0;
    logic [2:0]       ten    = 3'b000;
    logic             rstart = 1'b0;
    logic             rvalid = 1'b0;
    logic             rlast  = 1'b0;
    logic             rgood  = 1'b0;
    logic             rd_en  = 1'b0;
    logic [7:0]       rdata  = 8'h00;
    logic [2:0][17:0] rd_data_v;
    logic [2:0][15:0] fcnt_v, dcnt_v;
    logic [2:0]       dov, rdy;

    logic [1:0] cur = 2'd0;
    int         div = 1;
    int         checks = 0;
    int         errors = 0;
    int         rdy_seen [3] = '{0, 0, 0};

    always #5 tx_clk = ~tx_clk;

    rx_frame_buf u_dut_a (
        .tx_clk(tx_clk), .rst_n(rst_n), .clk_ten(ten[0]), .tsmac_rstart(rstart),
        .tsmac_rdata(rdata), .tsmac_rvalid(rvalid), .tsmac_rlast(rlast), .tsmac_rgood(rgood),
        .rd_en(rd_en), .rd_data(rd_data_v[0]), .data_out_valid(dov[0]), .frame_rdy(rdy[0]),
        .frame_cnt(fcnt_v[0]), .drop_cnt(dcnt_v[0])
    );

    rx_frame_buf #(.ADDR_W(6)) u_dut_b (
        .tx_clk(tx_clk), .rst_n(rst_n), .clk_ten(ten[1]), .tsmac_rstart(rstart),
        .tsmac_rdata(rdata), .tsmac_rvalid(rvalid), .tsmac_rlast(rlast), .tsmac_rgood(rgood),
        .rd_en(rd_en), .rd_data(rd_data_v[1]), .data_out_valid(dov[1]), .frame_rdy(rdy[1]),
        .frame_cnt(fcnt_v[1]), .drop_cnt(dcnt_v[1])
    );

    rx_frame_buf #(.FRAME_MAX(64)) u_dut_c (
        .tx_clk(tx_clk), .rst_n(rst_n), .clk_ten(ten[2]), .tsmac_rstart(rstart),
        .tsmac_rdata(rdata), .tsmac_rvalid(rvalid), .tsmac_rlast(rlast), .tsmac_rgood(rgood),
        .rd_en(rd_en), .rd_data(rd_data_v[2]), .data_out_valid(dov[2]), .frame_rdy(rdy[2]),
        .frame_cnt(fcnt_v[2]), .drop_cnt(dcnt_v[2])
    );

    // A frame_rdy pulse is counted on each enabled edge that sees it high.
    always @(posedge tx_clk) begin
        if (rdy[0] && ten[0]) rdy_seen[0]++;
        if (rdy[1] && ten[1]) rdy_seen[1]++;
        if (rdy[2] && ten[2]) rdy_seen[2]++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One enabled edge for the current instance, preceded by div-1 disabled edges.
    task automatic step();
        for (int i = 1; i < div; i++) begin
            ten = 3'b000;
            @(posedge tx_clk);
            #1;
        end
        ten = 3'b001 << cur;
        @(posedge tx_clk);
        #1;
        ten = 3'b000;
    endtask

    task automatic send_frame(input int len, input bit good, input int seed, input bit with_last);
        for (int i = 0; i < len; i++) begin
            rvalid = 1'b1;
            rstart = (i == 0);
            rlast  = with_last && (i == len - 1);
            rgood  = good;
            rdata  = 8'(seed + i);
            step();
        end
        rvalid = 1'b0;
        rstart = 1'b0;
        rlast  = 1'b0;
        rgood  = 1'b0;
    endtask

    function automatic int word_exp(input int idx, input int len, input int seed);
        return ((idx == len - 1) ? 256 : 0) + ((seed + idx) % 256);
    endfunction

    // Reads a whole frame with rd_en held, then one extra request that must be ignored.
    task automatic read_frame(input string tag, input int len, input int seed);
        rd_en = 1'b1;
        for (int i = 0; i < len; i++) begin
            step();
            check($sformatf("%s_w%0d", tag, i), 32'(rd_data_v[cur]), 32'(word_exp(i, len, seed)));
        end
        step();
        rd_en = 1'b0;
        check({tag, "_dov_low"}, 32'(dov[cur]), 32'd0);
        check({tag, "_hold"}, 32'(rd_data_v[cur]), 32'(word_exp(len - 1, len, seed)));
    endtask

    task automatic expect_status(input string tag, input int f, input int d, input int v);
        check({tag, "_frame_cnt"}, 32'(fcnt_v[cur]), 32'(f));
        check({tag, "_drop_cnt"}, 32'(dcnt_v[cur]), 32'(d));
        check({tag, "_dov"}, 32'(dov[cur]), 32'(v));
    endtask

    task automatic expect_cleared(input string tag);
        check({tag, "_rd_data"}, 32'(rd_data_v[cur]), 32'd0);
        check({tag, "_frame_rdy"}, 32'(rdy[cur]), 32'd0);
        expect_status(tag, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        repeat (3) @(posedge tx_clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            cur = 2'(k);
            expect_cleared($sformatf("reset_dut%0d", k));
        end
        rst_n = 1'b1;

        // Instance B, 64-word buffer: overflow drop, recovery, pointer wrap.
        cur = 2'd1;
        step();
        send_frame(70, 1'b1, 8'h00, 1'b1);
        expect_status("ovf_drop", 0, 1, 0);
        send_frame(20, 1'b1, 8'h30, 1'b1);
        expect_status("ovf_next", 1, 1, 1);
        read_frame("ovf_next", 20, 8'h30);
        send_frame(50, 1'b1, 8'h90, 1'b1);
        expect_status("wrap", 2, 1, 1);
        read_frame("wrap", 50, 8'h90);
        check("ovf_rdy_pulses", 32'(rdy_seen[1]), 32'd2);

        // Instance C, FRAME_MAX=64: length limit, single-byte frames, missing rlast.
        cur = 2'd2;
        send_frame(65, 1'b1, 8'h05, 1'b1);
        check("len65_rdy", 32'(rdy[2]), 32'd0);
        expect_status("len65", 0, 1, 0);
        send_frame(64, 1'b1, 8'hA0, 1'b1);
        expect_status("len64", 1, 1, 1);
        read_frame("len64", 64, 8'hA0);
        send_frame(80, 1'b1, 8'h00, 1'b1);
        expect_status("len80", 1, 2, 0);
        send_frame(1, 1'b0, 8'h66, 1'b1);
        expect_status("one_bad", 1, 3, 0);
        send_frame(1, 1'b1, 8'h77, 1'b1);
        expect_status("one_good", 2, 3, 1);
        read_frame("one_good", 1, 8'h77);
        send_frame(10, 1'b1, 8'h11, 1'b0);
        send_frame(5, 1'b1, 8'h33, 1'b1);
        expect_status("restart", 3, 4, 1);
        read_frame("restart", 5, 8'h33);
        check("len_rdy_pulses", 32'(rdy_seen[2]), 32'd3);

        // Instance A, defaults: basic frame, bad-then-good, coincident commit and last read.
        cur = 2'd0;
        send_frame(64, 1'b1, 8'h10, 1'b1);
        check("f64_rdy_high", 32'(rdy[0]), 32'd1);
        step();
        check("f64_rdy_low", 32'(rdy[0]), 32'd0);
        expect_status("f64", 1, 0, 1);
        read_frame("f64", 64, 8'h10);
        check("f64_rdy_pulses", 32'(rdy_seen[0]), 32'd1);

        send_frame(100, 1'b0, 8'h40, 1'b1);
        expect_status("bad100", 1, 1, 0);
        send_frame(60, 1'b1, 8'h80, 1'b1);
        expect_status("good60", 2, 1, 1);
        read_frame("good60", 60, 8'h80);

        send_frame(16, 1'b1, 8'h20, 1'b1);
        expect_status("pair_f1", 3, 1, 1);
        for (int c = 0; c <= 16; c++) begin
            rd_en  = (c < 16);
            rvalid = (c >= 7);
            rstart = (c == 7);
            rlast  = (c == 16);
            rgood  = 1'b1;
            rdata  = 8'(8'h60 + c - 7);
            step();
            if (c < 16) begin
                check($sformatf("pair_f1_w%0d", c), 32'(rd_data_v[0]), 32'(word_exp(c, 16, 8'h20)));
            end
            check($sformatf("pair_dov_c%0d", c), 32'(dov[0]), 32'd1);
        end
        rd_en  = 1'b0;
        rvalid = 1'b0;
        rstart = 1'b0;
        rlast  = 1'b0;
        step();
        expect_status("pair_f2", 4, 1, 1);
        read_frame("pair_f2", 10, 8'h60);

        // Sparse clock enable with a reset in the middle of a frame.
        div = 10;
        send_frame(8, 1'b1, 8'h50, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        expect_cleared("midrst");
        #2 rst_n = 1'b1;
        send_frame(12, 1'b1, 8'hC0, 1'b1);
        check("slow_rdy_high", 32'(rdy[0]), 32'd1);
        expect_status("slow", 1, 0, 1);
        read_frame("slow", 12, 8'hC0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
